debounce_sync: RTL and testbench
================================

# debounce_sync

Input conditioning stage for a raw, asynchronous 1-bit input, typically a push-button or switch. It sits directly upstream of the single-flip-flop capture stage and feeds it a clean level. The block synchronises the input into the `clk` domain with two flip-flops and filters bounce by requiring `STABLE_CYCLES` consecutive agreeing samples. It also emits one-cycle `rise`/`fall` pulses when the filtered level changes.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronised samples that must differ from `B` before `B` changes; legal range is 1 to 65535.
- `RESET_LEVEL`, default 0: value loaded into the synchroniser flops and `B` during reset.

Ports:
- `clk`  input  1  single clock; all state is updated on `posedge clk`.
- `rst_n`  input  1  asynchronous, active-low reset.
- `A`  input  1  raw asynchronous input; may glitch at any time.
- `B`  output  1  debounced level, registered.
- `rise`  output  1  one-cycle pulse when `B` goes 0→1, registered.
- `fall`  output  1  one-cycle pulse when `B` goes 1→0, registered.

## Operation
- Synchroniser:
  - `s1 <= A`, then `s2 <= s1`.
  - Only `s2` is used downstream; `A` never reaches logic directly.
- Counter `cnt`:
  - Width is `$clog2(STABLE_CYCLES+1)`, unsigned.
  - It never wraps, because it is cleared before it can exceed `STABLE_CYCLES-1`.
- FSM states:
  - IDLE: `s2 == B`.
  - COUNT: `s2 != B`, confirmation in progress.
- Rules applied at each edge:
  - IDLE, `s2 == B`: `cnt <= 0`, stay in IDLE.
  - IDLE, `s2 != B`, `STABLE_CYCLES == 1`: `B <= s2`, `cnt <= 0`, stay in IDLE.
  - IDLE, `s2 != B`, otherwise: `cnt <= 1`, go to COUNT.
  - COUNT, `s2 == B` (bounce): `cnt <= 0`, go to IDLE, no pulse.
  - COUNT, `s2 != B`, `cnt == STABLE_CYCLES-1`: `B <= s2`, `cnt <= 0`, go to IDLE, and pulse `rise` or `fall` per the new value.
  - COUNT, `s2 != B`, `cnt < STABLE_CYCLES-1`: `cnt <= cnt+1`.
- Pulse generation: `rise` and `fall` are 0 on every edge except the edge where `B` changes. They are never both 1.
- Reset values while `rst_n == 0`:
  - `s1`, `s2`, `B` = `RESET_LEVEL`.
  - `cnt` = 0, state = IDLE.
  - `rise` = 0, `fall` = 0.
- Reset asserted mid-count: all state clears immediately; the pending transition is discarded and no pulse is produced.
- Reset release with `A != RESET_LEVEL`: this is an ordinary debounce; the normal pulse follows after the full latency.

## Timing
- Define edge 0 as the first `posedge clk` that samples a new stable `A` into `s1`.
- Pipeline:
  - `s2` takes the new value at edge 1.
  - `cnt` counts over edges 2 .. `STABLE_CYCLES`.
  - `B` and the pulse update at edge `STABLE_CYCLES+1`.
- Latency is exactly `STABLE_CYCLES+2` edges counting edge 0; with the default this is 6 edges, and `B` changes at edge 5.
- Any disagreement in `s2` during edges 2 .. `STABLE_CYCLES+1` restarts the count from the next disagreement.
- Pulse width is exactly one `clk` period, high in the cycle following the updating edge and coincident with the new `B`.
- Back-to-back transitions: the minimum spacing between two `B` changes is `STABLE_CYCLES` edges.
- Asynchronous reset assertion forces outputs within the same cycle, without waiting for a clock edge.
- Reset deassertion is assumed synchronous to `clk` at system level; the block contains no reset synchroniser.

## Test plan
Unless noted, `STABLE_CYCLES=4` and `RESET_LEVEL=0`.
- Reset: hold `rst_n=0` for 3 cycles with `A` toggling. Required: `B=0`, `rise=0`, `fall=0` throughout; no pulse after release while `A=0`.
- Clean press: `A` 0→1 before edge 0 and held. Required:
  - `B=0` through edge 4.
  - `B=1` and `rise=1` after edge 5.
  - `rise=0` after edge 6.
  - No `fall` pulse.
- Bounce: `A=1` for 2 cycles, 0 for 1, then 1 held. Required:
  - No change until 4 consecutive agreeing `s2` samples.
  - `B` rises exactly 6 edges after the last 0→1 change of `A`.
  - Exactly one `rise` pulse.
- Release: from `B=1`, `A` 1→0 held. Required: `B=0` and `fall=1` for exactly one cycle at edge 5; `rise` stays 0.
- Reset mid-count: `A` 0→1, assert `rst_n=0` between edges 3 and 4, release 2 cycles later with `A=1`. Required:
  - Immediate return to `B=0`, `cnt=0`.
  - `B` rises 6 edges after the first post-release edge.
  - A single `rise` pulse.
- Parameter corners:
  - `STABLE_CYCLES=1`: `B` follows at edge 2.
  - `RESET_LEVEL=1`: `B=1` in reset; with `A=0` held, `fall` pulses at edge 5 after release.

Source files
------------

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchroniser plus counter debouncer with edge pulses
//
// Purpose:
//   Conditions a raw asynchronous 1-bit input, such as a button or switch.
//   The input passes through a two-flop synchroniser. The filtered level B
//   changes only after STABLE_CYCLES consecutive synchronised samples
//   disagree with it. On the edge where B changes, a one-cycle rise or fall
//   pulse is registered alongside the new level.
//
// Ports:
//   clk    in   1  clock; all state updates on posedge
//   rst_n  in   1  asynchronous active-low reset
//   A      in   1  raw asynchronous input
//   B      out  1  debounced level (registered)
//   rise   out  1  one-cycle pulse on B 0->1 (registered)
//   fall   out  1  one-cycle pulse on B 1->0 (registered)

module debounce_sync #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  output logic B,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // The count value on which the last confirming sample arrives.
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  logic          s1;
  logic          s2;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          b_nxt;
  logic          rise_nxt;
  logic          fall_nxt;

  // The raw input only ever reaches s1; everything downstream sees s2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= A;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      B     <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      B     <= b_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    b_nxt     = B;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (s2 == B) begin
          cnt_nxt = '0;
        end else if (STABLE_CYCLES == 1) begin
          // A single disagreeing sample is enough; commit without counting.
          b_nxt    = s2;
          cnt_nxt  = '0;
          rise_nxt = s2;
          fall_nxt = ~s2;
        end else begin
          cnt_nxt   = CW'(1);
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (s2 == B) begin
          // Bounce: throw away the partial count, no pulse.
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          b_nxt     = s2;
          cnt_nxt   = '0;
          state_nxt = IDLE;
          rise_nxt  = s2;
          fall_nxt  = ~s2;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed self-checking bench for debounce_sync

module tb_debounce_sync;

  logic clk;
  logic rst_n;
  logic a0, a1, a2;
  logic b0, r0, f0;
  logic b1, r1, f1;
  logic b2, r2, f2;

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debounce_sync u0 (
    .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .rise(r0), .fall(f0)
  );

  debounce_sync #(.STABLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .rise(r1), .fall(f1)
  );

  debounce_sync #(.RESET_LEVEL(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .rise(r2), .fall(f2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    a0 = 1'b0;
    a1 = 1'b0;
    a2 = 1'b0;

    // Reset held with a0 toggling
    #1;
    for (int i = 0; i < 3; i++) begin
      a0 = ~a0;
      step();
      chk("rst_b0",    {7'd0, b0}, 8'd0);
      chk("rst_rise0", {7'd0, r0}, 8'd0);
      chk("rst_fall0", {7'd0, f0}, 8'd0);
      chk("rst_b2_hi", {7'd0, b2}, 8'd1);
    end
    a0 = 1'b0;
    rst_n = 1'b1;

    // After release: u0 stays quiet, u2 (reset level 1, A=0) falls at edge 5
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_b0",   {7'd0, b0}, 8'd0);
      chk("post_rst_rise", {7'd0, r0}, 8'd0);
      chk("post_rst_fall", {7'd0, f0}, 8'd0);
      chk("rl1_b2",        {7'd0, b2}, (k < 5) ? 8'd1 : 8'd0);
      chk("rl1_fall2",     {7'd0, f2}, (k == 5) ? 8'd1 : 8'd0);
      chk("rl1_rise2",     {7'd0, r2}, 8'd0);
    end

    // Clean press on u0; same step on u1 (STABLE_CYCLES=1)
    a0 = 1'b1;
    a1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("press_b0",    {7'd0, b0}, (k >= 5) ? 8'd1 : 8'd0);
      chk("press_rise0", {7'd0, r0}, (k == 5) ? 8'd1 : 8'd0);
      chk("press_fall0", {7'd0, f0}, 8'd0);
      chk("sc1_b1",      {7'd0, b1}, (k >= 2) ? 8'd1 : 8'd0);
      chk("sc1_rise1",   {7'd0, r1}, (k == 2) ? 8'd1 : 8'd0);
    end

    // Release from B=1
    a0 = 1'b0;
    a1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rel_b0",    {7'd0, b0}, (k < 5) ? 8'd1 : 8'd0);
      chk("rel_fall0", {7'd0, f0}, (k == 5) ? 8'd1 : 8'd0);
      chk("rel_rise0", {7'd0, r0}, 8'd0);
      chk("sc1_b1_rel",  {7'd0, b1}, (k < 2) ? 8'd1 : 8'd0);
      chk("sc1_fall1",   {7'd0, f1}, (k == 2) ? 8'd1 : 8'd0);
    end

    // Bounce: 1,1,0 then 1 held; last 0->1 sampled at edge 3, B rises at edge 8
    a0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 1) a0 = 1'b0;
      if (k == 2) a0 = 1'b1;
      chk("bnc_b0",    {7'd0, b0}, (k >= 8) ? 8'd1 : 8'd0);
      chk("bnc_rise0", {7'd0, r0}, (k == 8) ? 8'd1 : 8'd0);
      chk("bnc_fall0", {7'd0, f0}, 8'd0);
    end

    // Return to 0 before the mid-count reset test
    a0 = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("settle_b0", {7'd0, b0}, 8'd0);

    // Reset mid-count: press, assert reset between edges 3 and 4
    a0 = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("mid_cnt_before", {5'd0, u0.cnt}, 8'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b0",  {7'd0, b0}, 8'd0);
    chk("mid_rst_cnt", {5'd0, u0.cnt}, 8'd0);
    chk("mid_rst_rise", {7'd0, r0}, 8'd0);
    step();
    step();
    chk("mid_rst_hold_b0", {7'd0, b0}, 8'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("mid_post_b0",    {7'd0, b0}, (k >= 5) ? 8'd1 : 8'd0);
      chk("mid_post_rise0", {7'd0, r0}, (k == 5) ? 8'd1 : 8'd0);
      chk("mid_post_fall0", {7'd0, f0}, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
